// File: rtl/wb_arbiter_n.sv
// wb_arbiter_n: round-robin Wishbone shared-bus interconnect with address decode and cyc-span locking.
// Optional bus watchdog that turns a silent slave into err is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_n #(
    parameter int                          num_masters = 4,
    parameter int                          num_slaves  = 8,
    parameter int                          dec_w       = 4,
    parameter logic [num_slaves*dec_w-1:0] slave_addrs = 32'h7654_3210,
    parameter int                          timeout     = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [num_masters*32-1:0] m_adr_i,
    input  logic [num_masters*32-1:0] m_dat_i,
    input  logic [num_masters*4-1:0]  m_sel_i,
    input  logic [num_masters-1:0]    m_we_i,
    input  logic [num_masters-1:0]    m_cyc_i,
    input  logic [num_masters-1:0]    m_stb_i,
    output logic [31:0]               m_dat_o,
    output logic [num_masters-1:0]    m_ack_o,
    output logic [num_masters-1:0]    m_err_o,
    output logic [num_masters-1:0]    m_rty_o,
    output logic [31:0]               s_adr_o,
    output logic [31:0]               s_dat_o,
    output logic [3:0]                s_sel_o,
    output logic                      s_we_o,
    output logic [num_slaves-1:0]     s_cyc_o,
    output logic [num_slaves-1:0]     s_stb_o,
    input  logic [num_slaves*32-1:0]  s_dat_i,
    input  logic [num_slaves-1:0]     s_ack_i,
    input  logic [num_slaves-1:0]     s_err_i,
    input  logic [num_slaves-1:0]     s_rty_i,
    output logic [num_masters-1:0]    gnt_o
);
    localparam int mw = (num_masters > 1) ? $clog2(num_masters) : 1;
    localparam int sw = (num_slaves > 1) ? $clog2(num_slaves) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                 state, state_next;
    logic [mw-1:0]          owner, owner_next, last, last_next, mux_idx;
    logic [mw-1:0]          cand, winner;
    logic [num_masters-1:0] gnt_next;
    logic                   found, hold, owned, own_cyc, own_stb;
    logic [sw-1:0]          slv;
    logic                   hit, sl_ack, sl_err, sl_rty;
    logic                   unm_err, tmo_err;

    // Round-robin search starting just above the last granted master, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = last;
        for (int k = 0; k < num_masters; k++) begin
            cand = (cand == mw'(num_masters - 1)) ? '0 : cand + 1'b1;
            if (!found && m_cyc_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign hold = (state == OWNED) && m_cyc_i[owner];

    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last;
        gnt_next   = gnt_o;
        if (!hold) begin
            if (found) begin
                state_next       = OWNED;
                owner_next       = winner;
                last_next        = winner;
                gnt_next         = '0;
                gnt_next[winner] = 1'b1;
            end else begin
                state_next = IDLE;
                owner_next = '0;
                gnt_next   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            last  <= mw'(num_masters - 1);
            gnt_o <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            last  <= last_next;
            gnt_o <= gnt_next;
        end
    end

    assign owned   = (state == OWNED);
    assign mux_idx = owned ? owner : '0;
    assign own_cyc = owned & m_cyc_i[mux_idx];
    assign own_stb = own_cyc & m_stb_i[mux_idx];

    assign s_adr_o = m_adr_i[{mux_idx, 5'd0} +: 32];
    assign s_dat_o = m_dat_i[{mux_idx, 5'd0} +: 32];
    assign s_sel_o = m_sel_i[{mux_idx, 2'd0} +: 4];
    assign s_we_o  = m_we_i[mux_idx];

    // Scanning downward leaves the lowest matching slave index in slv.
    always_comb begin
        hit = 1'b0;
        slv = '0;
        for (int k = num_slaves - 1; k >= 0; k--) begin
            if (s_adr_o[31 -: dec_w] == slave_addrs[k*dec_w +: dec_w]) begin
                hit = 1'b1;
                slv = sw'(k);
            end
        end
    end

    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        if (hit) begin
            s_cyc_o[slv] = own_cyc;
            s_stb_o[slv] = own_stb;
        end
    end

    assign sl_ack  = hit & s_ack_i[slv];
    assign sl_err  = hit & s_err_i[slv];
    assign sl_rty  = hit & s_rty_i[slv];
    assign m_dat_o = s_dat_i[{slv, 5'd0} +: 32];

    // Unmapped strobe: err one cycle after it is seen, then every other cycle while held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            unm_err <= 1'b0;
        end else begin
            unm_err <= own_stb & ~hit & ~unm_err;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int cw = ($clog2(timeout + 1) > 8) ? $clog2(timeout + 1) : 8;

    logic [cw-1:0] tmo_cnt;
    logic          fwd_stb, sl_term;

    assign fwd_stb = own_stb & hit;
    assign sl_term = sl_ack | sl_err | sl_rty;
    assign tmo_err = fwd_stb & ~sl_term & (tmo_cnt == cw'(timeout));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (!fwd_stb || sl_term || tmo_err || (gnt_next != gnt_o)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_err = 1'b0;
`endif

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (owned) begin
            m_ack_o[mux_idx] = own_cyc & sl_ack;
            m_rty_o[mux_idx] = own_cyc & sl_rty;
            m_err_o[mux_idx] = (own_cyc & sl_err) | unm_err | tmo_err;
        end
    end
endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed self-checking bench for wb_arbiter_n (4 masters, 8 slaves, default address map).
// Timeout length is 16 when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter_n;
    localparam int NM = 4;
    localparam int NS = 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [NM*32-1:0] m_adr_i, m_dat_i;
    logic [NM*4-1:0]  m_sel_i;
    logic [NM-1:0]    m_we_i, m_cyc_i, m_stb_i;
    logic [31:0]      m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o, gnt_o;
    logic [31:0]      s_adr_o, s_dat_o;
    logic [3:0]       s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_cyc_o, s_stb_o;
    logic [NS*32-1:0] s_dat_i;
    logic [NS-1:0]    s_ack_i, s_err_i, s_rty_i, man_ack;
    logic             auto_ack;
    int               n_cmp = 0;
    int               n_bad = 0;

    // Optional zero-wait slave model: acks any forwarded strobe in the same cycle.
    assign s_ack_i = man_ack | (auto_ack ? s_stb_o : '0);

    always #5 clk = ~clk;

    wb_arbiter_n #(.num_masters(NM), .num_slaves(NS), .timeout(TMO)) dut (
        .clk(clk), .reset(reset),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic [31:0] adr);
        m_cyc_i[m]          = cyc;
        m_stb_i[m]          = stb;
        m_we_i[m]           = 1'b0;
        m_adr_i[m*32 +: 32] = adr;
        m_dat_i[m*32 +: 32] = 32'hA000_0000 | 32'(m);
        m_sel_i[m*4 +: 4]   = 4'hF;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ohIndex(input logic [NM-1:0] v);
        int r = 99;
        int c = 0;
        for (int i = 0; i < NM; i++) begin
            if (v[i]) begin
                r = i;
                c++;
            end
        end
        if (c != 1) r = 99;
        return r;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            rec[6];
        int            exp_rot[6] = '{0, 1, 3, 0, 1, 3};
        int            n_rec;
        int            err_at;
        int            n_term;
        logic [NM-1:0] acked;

        reset    = 1'b1;
        auto_ack = 1'b0;
        man_ack  = '0;
        s_err_i  = '0;
        s_rty_i  = '0;
        m_adr_i  = '0;
        m_dat_i  = '0;
        m_sel_i  = '0;
        m_we_i   = '0;
        m_cyc_i  = '0;
        m_stb_i  = '0;
        for (int k = 0; k < NS; k++) s_dat_i[k*32 +: 32] = 32'hD000_0000 + 32'(k);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_gnt", 64'(gnt_o), 64'h0);
        checkOutput("rst_scyc", 64'(s_cyc_o), 64'h0);
        checkOutput("rst_sstb", 64'(s_stb_o), 64'h0);
        checkOutput("rst_mterm", 64'({m_ack_o, m_err_o, m_rty_o}), 64'h0);
        reset = 1'b0;

        // Single read by master 1 to slave 7.
        tick();
        applyStimulus(1, 1'b1, 1'b1, 32'h7000_0000);
        #1;
        checkOutput("idle_gnt", 64'(gnt_o), 64'h0);
        tick();
        checkOutput("m1_gnt", 64'(gnt_o), 64'h2);
        checkOutput("m1_sstb", 64'(s_stb_o), 64'h80);
        checkOutput("m1_scyc", 64'(s_cyc_o), 64'h80);
        checkOutput("m1_sadr", 64'(s_adr_o), 64'h7000_0000);
        checkOutput("m1_sdat", 64'(s_dat_o), 64'hA000_0001);
        man_ack[7] = 1'b1;
        #1;
        checkOutput("m1_ack", 64'(m_ack_o), 64'h2);
        checkOutput("m1_rdat", 64'(m_dat_o), 64'hD000_0007);
        tick();
        man_ack    = '0;
        s_rty_i[7] = 1'b1;
        #1;
        checkOutput("m1_rty", 64'(m_rty_o), 64'h2);
        checkOutput("m1_noack", 64'(m_ack_o), 64'h0);
        tick();
        s_rty_i = '0;
        applyStimulus(1, 1'b0, 1'b0, 32'h7000_0000);
        tick();
        checkOutput("m1_release", 64'(gnt_o), 64'h0);

        // Round-robin rotation among masters 0, 1, 3 starting from reset.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        auto_ack = 1'b1;
        for (int i = 0; i < 6; i++) rec[i] = 99;
        n_rec = 0;
        applyStimulus(0, 1'b1, 1'b1, 32'h3000_0000);
        applyStimulus(1, 1'b1, 1'b1, 32'h3000_0000);
        applyStimulus(3, 1'b1, 1'b1, 32'h3000_0000);
        for (int c = 0; c < 40 && n_rec < 6; c++) begin
            @(negedge clk);
            if (m_ack_o != '0) begin
                rec[n_rec] = ohIndex(m_ack_o);
                n_rec++;
            end
            acked = m_ack_o;
            tick();
            for (int i = 0; i < NM; i++) begin
                if (i != 2) begin
                    if (acked[i]) applyStimulus(i, 1'b0, 1'b0, 32'h3000_0000);
                    else if (!m_cyc_i[i]) applyStimulus(i, 1'b1, 1'b1, 32'h3000_0000);
                end
            end
        end
        for (int k = 0; k < 6; k++) checkOutput($sformatf("rot%0d", k), 64'(rec[k]), 64'(exp_rot[k]));
        m_cyc_i = '0;
        m_stb_i = '0;
        tick();
        tick();

        // Master 2 locks the bus for four acked strobes while master 0 waits.
        applyStimulus(2, 1'b1, 1'b1, 32'h2000_0000);
        tick();
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0000);
        n_term = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checkOutput($sformatf("lock_gnt%0d", c), 64'(gnt_o), 64'h4);
            if (m_ack_o == 4'b0100) n_term++;
            tick();
        end
        checkOutput("lock_acks", 64'(n_term), 64'd4);
        applyStimulus(2, 1'b0, 1'b0, 32'h2000_0000);
        #1;
        checkOutput("hand_gap_gnt", 64'(gnt_o), 64'h4);
        checkOutput("hand_gap_stb", 64'(s_stb_o), 64'h0);
        tick();
        checkOutput("hand_gnt", 64'(gnt_o), 64'h1);
        checkOutput("hand_stb", 64'(s_stb_o), 64'h01);
        checkOutput("hand_ack", 64'(m_ack_o), 64'h1);
        applyStimulus(0, 1'b0, 1'b0, 32'h0000_0000);
        auto_ack = 1'b0;
        tick();
        tick();

        // Unmapped address from master 3.
        applyStimulus(3, 1'b1, 1'b1, 32'hF000_0000);
        tick();
        checkOutput("unm_gnt", 64'(gnt_o), 64'h8);
        checkOutput("unm_sstb", 64'(s_stb_o), 64'h0);
        checkOutput("unm_scyc", 64'(s_cyc_o), 64'h0);
        checkOutput("unm_err0", 64'(m_err_o), 64'h0);
        tick();
        checkOutput("unm_err1", 64'(m_err_o), 64'h8);
        tick();
        checkOutput("unm_err2", 64'(m_err_o), 64'h0);
        tick();
        checkOutput("unm_err3", 64'(m_err_o), 64'h8);
        applyStimulus(3, 1'b0, 1'b0, 32'hF000_0000);
        tick();
        tick();

        // Silent slave 5 accessed by master 1.
        applyStimulus(1, 1'b1, 1'b1, 32'h5000_0000);
        tick();
        checkOutput("tmo_gnt", 64'(gnt_o), 64'h2);
        checkOutput("tmo_sstb", 64'(s_stb_o), 64'h20);
`ifdef WB_ARB_TIMEOUT_EN
        err_at = -1;
        for (int c = 0; c < 40 && err_at < 0; c++) begin
            if (m_err_o[1]) err_at = c;
            tick();
        end
        checkOutput("tmo_cycle", 64'(err_at), 64'd16);
`else
        err_at = 0;
        n_term = 0;
        for (int c = 0; c < 1000; c++) begin
            if ((m_ack_o | m_err_o | m_rty_o) != '0) n_term++;
            tick();
        end
        checkOutput("stall_terms", 64'(n_term), 64'd0);
        checkOutput("stall_sstb", 64'(s_stb_o), 64'h20);
`endif
        applyStimulus(1, 1'b0, 1'b0, 32'h5000_0000);
        tick();
        tick();

        // Asynchronous reset while master 0 has a strobe at slave 2 and master 1 waits.
        auto_ack = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, 32'h2000_0000);
        tick();
        applyStimulus(1, 1'b1, 1'b1, 32'h1000_0000);
        #1;
        checkOutput("mid_gnt", 64'(gnt_o), 64'h1);
        checkOutput("mid_sstb", 64'(s_stb_o), 64'h04);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("arst_gnt", 64'(gnt_o), 64'h0);
        checkOutput("arst_sstb", 64'(s_stb_o), 64'h0);
        checkOutput("arst_scyc", 64'(s_cyc_o), 64'h0);
        checkOutput("arst_mterm", 64'({m_ack_o, m_err_o, m_rty_o}), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        checkOutput("post_rst_gnt", 64'(gnt_o), 64'h1);
        m_cyc_i  = '0;
        m_stb_i  = '0;
        auto_ack = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
